hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV64 pipeline; drives operand-forward selects for the decode-stage operand mux and the pipeline stall/bubble/flush controls.
- Keeps its own shadow copy of destination info for EX, MEM and WB, updated each cycle the pipeline advances.
- Sequences load-use stalls, multi-cycle MDU occupancy, memory wait and branch-redirect flushes.

Parameters:
- REG_ADDR_WIDTH, 5, register index width
- MDU_LAT, 8, total EX cycles a mul/div op occupies (min 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  instruction present in ID
- id_rs1  in  REG_ADDR_WIDTH  ID source 1 index
- id_rs2  in  REG_ADDR_WIDTH  ID source 2 index
- id_rs1_used  in  1  rs1 actually read
- id_rs2_used  in  1  rs2 actually read
- id_rd  in  REG_ADDR_WIDTH  ID destination index
- id_wen  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_is_mdu  in  1  ID instruction is mul/div
- mem_ready  in  1  MEM-stage access complete this cycle
- ex_redirect  in  1  taken branch/jump resolved in EX
- fwd_sel1  out  2  rs1 source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
- fwd_sel2  out  2  rs2 source, same encoding
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  inject NOP into ID/EX
- hold_ex  out  1  hold ID/EX and EX/MEM registers (MDU busy or memory wait)
- flush_id  out  1  squash IF/ID contents
- mdu_busy  out  1  MDU occupying EX

Behaviour:
- Reset (asynchronous, rst_n=0): all shadow valid bits 0, FSM = IDLE, MDU counter 0. All outputs 0 while in reset and on the first cycle after release.
- Shadow pipe: each entry holds {valid, rd, wen, is_load}.
  - Advances (ID→EX→MEM→WB) on rising clk when adv = mem_ready & (state != MDU_BUSY).
  - EX entry loads a bubble (valid=0) when bubble_ex or flush_id is asserted.
  - WB entry is retired each advance.
- Forwarding (combinational from shadow state and ID inputs, zero latency):
  - Per source: match when src_used & src != 0 & stage.valid & stage.wen & stage.rd == src.
  - Priority EX > MEM > WB, otherwise 00.
  - An EX match whose entry has is_load = 1 never selects 01; it raises a load-use hazard instead.
- FSM states: IDLE, LOAD_STALL, MDU_BUSY, MEM_WAIT.
  - IDLE → LOAD_STALL: load-use hazard & id_valid & !ex_redirect. In that cycle stall_if_id=1 and bubble_ex=1.
  - LOAD_STALL → IDLE after exactly one cycle. The load is now in MEM, so the next cycle selects 10.
  - IDLE → MDU_BUSY: an MDU op advances into EX. Counter loads MDU_LAT-1.
  - In MDU_BUSY: mdu_busy=1, hold_ex=1, stall_if_id=1. Counter decrements each cycle; exit to IDLE when it reaches 1, so EX is occupied for MDU_LAT cycles total.
  - Any state → MEM_WAIT while mem_ready=0: stall_if_id=1, hold_ex=1, shadow frozen. Return to the prior state class when mem_ready=1.
  - MDU counter is frozen during MEM_WAIT.
- ex_redirect:
  - flush_id=1 the same cycle; overrides load-use (no stall, bubble only).
  - Redirect is never asserted in MDU_BUSY; the bench treats this as an assertion error, and the RTL ignores it.
- Simultaneous events: mem_ready=0 dominates all others. Redirect dominates load-use. A load-use hazard and an MDU op entering EX cannot coexist.
- Reset mid-operation: immediately returns to IDLE and clears all shadows and the counter; no stall persists.

Decomposition:
- Shared defines:
  - REG_ADDR_WIDTH
  - forward-select encodings FWD_RF / FWD_EX / FWD_MEM / FWD_WB
  - FSM state encodings
  - MDU_LAT default
- Sub-module fwd_match: a pure combinational per-source priority matcher, instantiated twice (rs1, rs2). It outputs the select and a load-use flag.

Test Plan:
1. addi x5 in EX (wen=1), ID reads rs1=x5 → fwd_sel1=01, fwd_sel2=00, no stall.
2. ld x5 in EX, ID rs2=x5 → stall_if_id=1 and bubble_ex=1 for exactly 1 cycle; next cycle fwd_sel2=10.
3. EX and MEM both write x7, ID reads rs1=x7 → fwd_sel1=01. With rd=x0 in all stages and rs1=x0 → fwd_sel1=00.
4. MDU_LAT=4, mul enters EX → mdu_busy=1, hold_ex=1, stall_if_id=1 for 3 cycles, then IDLE. With mem_ready=0 for 2 of those cycles, busy extends to 5 cycles.
5. Load-use hazard coincident with ex_redirect=1 → flush_id=1, stall_if_id=0, EX receives a bubble, FSM stays IDLE.
6. rst_n deasserted mid MDU_BUSY (counter=2) → all outputs 0 immediately; after release, fwd_sel=00 for any rs.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants and encodings for the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int MDU_LAT_DEF    = 8;

  // Operand source select driven to the decode-stage operand mux
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOAD_STALL = 2'b01,
    MDU_BUSY   = 2'b10,
    MEM_WAIT   = 2'b11
  } state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// Per-source forwarding matcher: picks the youngest stage that writes the
// source register, and flags a load-use hazard when that stage is a load in EX.
module hazard_fwd_ctrl_fwd_match #(
  parameter int REG_ADDR_WIDTH = hazard_fwd_ctrl_pkg::REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic                      used,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_wen,
  input  logic                      ex_is_load,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_wen,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_wen,
  output logic [1:0]                sel,
  output logic                      load_use
);
  import hazard_fwd_ctrl_pkg::*;

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero, so it never forwards
  assign live    = used & (src != '0);
  assign ex_hit  = live & ex_valid  & ex_wen  & (ex_rd  == src);
  assign mem_hit = live & mem_valid & mem_wen & (mem_rd == src);
  assign wb_hit  = live & wb_valid  & wb_wen  & (wb_rd  == src);

  // Priority EX > MEM > WB; a load in EX has no data yet, so it stalls instead
  always_comb begin
    sel      = FWD_RF;
    load_use = 1'b0;
    if (ex_hit && ex_is_load) begin
      load_use = 1'b1;
    end
    if (ex_hit && !ex_is_load) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks shadow
// destination info for EX/MEM/WB and sequences load-use, MDU and memory stalls.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_WIDTH = hazard_fwd_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int MDU_LAT        = hazard_fwd_ctrl_pkg::MDU_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic                      id_is_mdu,
  input  logic                      mem_ready,
  input  logic                      ex_redirect,
  output logic [1:0]                fwd_sel1,
  output logic [1:0]                fwd_sel2,
  output logic                      stall_if_id,
  output logic                      bubble_ex,
  output logic                      hold_ex,
  output logic                      flush_id,
  output logic                      mdu_busy
);
  import hazard_fwd_ctrl_pkg::*;

  localparam int              CNT_W    = $clog2(MDU_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  state_e                    state, next_state;
  logic                      resume_mdu, next_resume_mdu;
  logic [CNT_W-1:0]          cnt, next_cnt;

  // Only the EX copy of is_load matters: by MEM the load data is available
  logic                      ex_valid, ex_wen, ex_is_load;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      mem_valid, mem_wen;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      wb_valid, wb_wen;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;

  logic lu1, lu2, load_use, eff_mdu, adv;

  hazard_fwd_ctrl_fwd_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match1 (
    .src(id_rs1), .used(id_rs1_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wen(mem_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .sel(fwd_sel1), .load_use(lu1)
  );

  hazard_fwd_ctrl_fwd_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_match2 (
    .src(id_rs2), .used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wen(mem_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .sel(fwd_sel2), .load_use(lu2)
  );

  assign load_use = id_valid & (lu1 | lu2);
  // A memory wait that interrupted an MDU op still counts as MDU occupancy
  assign eff_mdu  = (state == MDU_BUSY) | ((state == MEM_WAIT) & resume_mdu);
  assign adv      = mem_ready & ~eff_mdu;

  // Next-state and control outputs; memory wait dominates, then MDU, redirect, load-use
  always_comb begin
    next_state      = state;
    next_cnt        = cnt;
    next_resume_mdu = resume_mdu;
    stall_if_id     = 1'b0;
    bubble_ex       = 1'b0;
    hold_ex         = 1'b0;
    flush_id        = 1'b0;
    mdu_busy        = 1'b0;
    if (!mem_ready) begin
      next_state      = MEM_WAIT;
      next_resume_mdu = eff_mdu;
      stall_if_id     = 1'b1;
      hold_ex         = 1'b1;
      mdu_busy        = eff_mdu;
    end else if (eff_mdu) begin
      mdu_busy    = 1'b1;
      hold_ex     = 1'b1;
      stall_if_id = 1'b1;
      if (cnt <= CNT_W'(1)) begin
        next_state      = IDLE;
        next_cnt        = '0;
        next_resume_mdu = 1'b0;
      end else begin
        next_state = MDU_BUSY;
        next_cnt   = cnt - CNT_W'(1);
      end
    end else begin
      next_state      = IDLE;
      next_resume_mdu = 1'b0;
      if (ex_redirect) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
        next_state  = LOAD_STALL;
      end else if (id_valid && id_is_mdu) begin
        next_state = MDU_BUSY;
        next_cnt   = CNT_LOAD;
      end
    end
  end

  // State register, MDU countdown and resume marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resume_mdu <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      resume_mdu <= next_resume_mdu;
    end
  end

  // Shadow destination pipe, moving in lockstep with the real pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_wen     <= 1'b0;
      ex_is_load <= 1'b0;
      mem_valid  <= 1'b0;
      mem_rd     <= '0;
      mem_wen    <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_wen     <= 1'b0;
    end else if (adv) begin
      wb_valid   <= mem_valid;
      wb_rd      <= mem_rd;
      wb_wen     <= mem_wen;
      mem_valid  <= ex_valid;
      mem_rd     <= ex_rd;
      mem_wen    <= ex_wen;
      ex_valid   <= id_valid & ~(bubble_ex | flush_id);
      ex_rd      <= id_rd;
      ex_wen     <= id_wen;
      ex_is_load <= id_is_load;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed, table-driven bench for hazard_fwd_ctrl (MDU_LAT = 4).
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_wen;
  logic       id_is_load;
  logic       id_is_mdu;
  logic       mem_ready;
  logic       ex_redirect;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       hold_ex;
  logic       flush_id;
  logic       mdu_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
    logic       mdu;
    logic       mrdy;
    logic       redir;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       st;
    logic       bu;
    logic       ho;
    logic       fl;
    logic       bz;
  } vec_t;

  vec_t vecs[24];

  hazard_fwd_ctrl #(.REG_ADDR_WIDTH(5), .MDU_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .mem_ready(mem_ready), .ex_redirect(ex_redirect),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .hold_ex(hold_ex),
    .flush_id(flush_id), .mdu_busy(mdu_busy)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A redirect while the MDU occupies EX is an illegal stimulus
  always @(negedge clk) begin
    if (rst_n && ex_redirect && mdu_busy) $error("[TB] redirect asserted while MDU busy");
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input int v, input int rs1, input int u1, input int rs2,
                              input int u2, input int rd, input int wen, input int ld,
                              input int mdu, input int mrdy, input int redir,
                              input int s1, input int s2, input int st, input int bu,
                              input int ho, input int fl, input int bz);
    vec_t r;
    r.v = 1'(v);     r.rs1 = 5'(rs1); r.u1 = 1'(u1);   r.rs2 = 5'(rs2); r.u2 = 1'(u2);
    r.rd = 5'(rd);   r.wen = 1'(wen); r.ld = 1'(ld);   r.mdu = 1'(mdu);
    r.mrdy = 1'(mrdy); r.redir = 1'(redir);
    r.s1 = 2'(s1);   r.s2 = 2'(s2);   r.st = 1'(st);   r.bu = 1'(bu);
    r.ho = 1'(ho);   r.fl = 1'(fl);   r.bz = 1'(bz);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    id_valid    = s.v;
    id_rs1      = s.rs1;
    id_rs1_used = s.u1;
    id_rs2      = s.rs2;
    id_rs2_used = s.u2;
    id_rd       = s.rd;
    id_wen      = s.wen;
    id_is_load  = s.ld;
    id_is_mdu   = s.mdu;
    mem_ready   = s.mrdy;
    ex_redirect = s.redir;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectCtl(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                           input logic st, input logic bu, input logic ho,
                           input logic fl, input logic bz);
    checkOutput({tag, ".fwd_sel1"},    fwd_sel1, s1);
    checkOutput({tag, ".fwd_sel2"},    fwd_sel2, s2);
    checkOutput({tag, ".stall_if_id"}, {1'b0, stall_if_id}, {1'b0, st});
    checkOutput({tag, ".bubble_ex"},   {1'b0, bubble_ex},   {1'b0, bu});
    checkOutput({tag, ".hold_ex"},     {1'b0, hold_ex},     {1'b0, ho});
    checkOutput({tag, ".flush_id"},    {1'b0, flush_id},    {1'b0, fl});
    checkOutput({tag, ".mdu_busy"},    {1'b0, mdu_busy},    {1'b0, bz});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic mr_pat[6];
    logic bz_pat[6];
    // v rs1 u1 rs2 u2 rd wen ld mdu mrdy redir | s1 s2 st bu ho fl bz
    vecs[0]  = mk(0, 0,0, 0,0,  0,0,0,0,1,0, 0,0,0,0,0,0,0);
    vecs[1]  = mk(1, 0,0, 0,0,  5,1,0,0,1,0, 0,0,0,0,0,0,0);
    vecs[2]  = mk(1, 5,1, 6,1,  6,1,0,0,1,0, 1,0,0,0,0,0,0);
    vecs[3]  = mk(1, 5,1, 6,1,  0,0,0,0,1,0, 2,1,0,0,0,0,0);
    vecs[4]  = mk(1, 5,1, 6,1,  7,1,0,0,1,0, 3,2,0,0,0,0,0);
    vecs[5]  = mk(1, 0,0, 0,0,  7,1,0,0,1,0, 0,0,0,0,0,0,0);
    vecs[6]  = mk(1, 7,1, 0,1,  0,0,0,0,1,0, 1,0,0,0,0,0,0);
    vecs[7]  = mk(1, 7,1, 0,0,  0,1,0,0,1,0, 2,0,0,0,0,0,0);
    vecs[8]  = mk(1, 0,1, 7,1,  0,1,0,0,1,0, 0,3,0,0,0,0,0);
    vecs[9]  = mk(1, 0,1, 0,1,  0,1,0,0,1,0, 0,0,0,0,0,0,0);
    vecs[10] = mk(0, 0,1, 0,1,  0,0,0,0,1,0, 0,0,0,0,0,0,0);
    vecs[11] = mk(1, 0,0, 0,0,  5,1,1,0,1,0, 0,0,0,0,0,0,0);
    vecs[12] = mk(1, 0,0, 5,1,  8,1,0,0,1,0, 0,0,1,1,0,0,0);
    vecs[13] = mk(1, 0,0, 5,1,  8,1,0,0,1,0, 0,2,0,0,0,0,0);
    vecs[14] = mk(1, 5,1, 8,1,  9,1,0,0,1,0, 3,1,0,0,0,0,0);
    vecs[15] = mk(1, 0,0, 0,0, 10,1,1,0,1,0, 0,0,0,0,0,0,0);
    vecs[16] = mk(1,10,1, 0,0, 11,1,0,0,1,1, 0,0,0,1,0,1,0);
    vecs[17] = mk(1,10,1,11,1, 12,1,0,0,1,0, 2,0,0,0,0,0,0);
    vecs[18] = mk(1,12,1, 0,0, 13,1,0,0,1,1, 1,0,0,1,0,1,0);
    vecs[19] = mk(1,13,1,12,1,  0,0,0,0,1,0, 0,2,0,0,0,0,0);
    vecs[20] = mk(1,12,1, 0,0,  0,0,0,0,0,0, 3,0,1,0,1,0,0);
    vecs[21] = mk(1,12,1, 0,0,  0,0,0,0,0,0, 3,0,1,0,1,0,0);
    vecs[22] = mk(1,12,1, 0,0,  0,0,0,0,1,0, 3,0,0,0,0,0,0);
    vecs[23] = mk(1,12,1, 0,0,  0,0,0,0,1,0, 0,0,0,0,0,0,0);

    rst_n = 1'b0;
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0));
    #12;
    expectCtl("in_reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    expectCtl("first_cycle", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      #3;
      expectCtl($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].st,
                vecs[i].bu, vecs[i].ho, vecs[i].fl, vecs[i].bz);
      nextCycle();
    end

    // mul enters EX and occupies it for MDU_LAT cycles
    applyStimulus(mk(1,0,0,0,0,14,1,0,1,1,0, 0,0,0,0,0,0,0));
    #3;
    expectCtl("mdu_issue", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    for (int c = 1; c <= 4; c++) begin
      logic b;
      b = (c <= 3);
      applyStimulus(mk(1,14,1,0,0,15,1,0,0,1,0, 0,0,0,0,0,0,0));
      #3;
      expectCtl($sformatf("mdu4_c%0d", c), 1, 0, b, 0, b, 0, b);
      nextCycle();
    end

    // second mul with a two-cycle memory wait in the middle
    applyStimulus(mk(1,14,1,0,0,16,1,0,1,1,0, 0,0,0,0,0,0,0));
    #3;
    expectCtl("mdu_issue2", 2, 0, 0, 0, 0, 0, 0);
    nextCycle();
    mr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bz_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      applyStimulus(mk(1,16,1,0,0,17,1,0,0,int'(mr_pat[c]),0, 0,0,0,0,0,0,0));
      #3;
      expectCtl($sformatf("mdu_wait_c%0d", c), 1, 0, bz_pat[c], 0, bz_pat[c], 0, bz_pat[c]);
      nextCycle();
    end

    // reset asserted mid-MDU with the counter at 2
    applyStimulus(mk(1,0,0,0,0,18,1,0,1,1,0, 0,0,0,0,0,0,0));
    #3;
    expectCtl("mdu_issue3", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(mk(1,18,1,18,1,19,1,0,0,1,0, 0,0,0,0,0,0,0));
    #3;
    expectCtl("mdu3_cnt3", 1, 1, 1, 0, 1, 0, 1);
    nextCycle();
    #3;
    expectCtl("mdu3_cnt2", 1, 1, 1, 0, 1, 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    expectCtl("reset_mid", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(mk(0,0,1,0,1,0,0,0,0,1,0, 0,0,0,0,0,0,0));
    for (int k = 0; k < 4; k++) begin
      int rs;
      rs = (k == 0) ? 1 : (k == 1) ? 5 : (k == 2) ? 18 : 31;
      id_rs1 = 5'(rs);
      id_rs2 = 5'(rs);
      #1;
      expectCtl($sformatf("post_reset_rs%0d", rs), 0, 0, 0, 0, 0, 0, 0);
    end
    nextCycle();
    id_rs1 = 5'd18;
    id_rs2 = 5'd19;
    #3;
    expectCtl("post_reset_c2", 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
